// File: rtl/seven_segment_scan_if.sv
// Bus between the game datapath and the seven-segment scanner:
// shadow-load strobe, live display masks and the shared pin outputs.
interface seven_segment_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank_mask;
    logic [DIGITS-1:0]     blink_mask;
    logic                  lz_en;
    logic [6:0]            seg;
    logic                  dp_n;
    logic [DIGITS-1:0]     an;

    modport master (
        output load, value, dp, blank_mask, blink_mask, lz_en,
        input  seg, dp_n, an
    );

    modport slave (
        input  load, value, dp, blank_mask, blink_mask, lz_en,
        output seg, dp_n, an
    );
endinterface

// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode hex display driver with blink,
// blanking, leading-zero suppression and a guard cycle per slot.
module seven_segment_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input logic                 clk,
    input logic                 rst,
    seven_segment_scan_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [FW-1:0]        fcnt;
    logic                 phase_on;
    logic [4*DIGITS-1:0]  sh_value;
    logic [DIGITS-1:0]    sh_dp;
    logic                 slot_end;
    logic                 frame_end;
    logic [DIGITS-1:0]    lz_sup;
    logic                 zero_run;
    logic [DIGITS-1:0]    an_lit;
    logic [3:0]           nib;
    logic                 dark;
    logic [6:0]           seg_q;
    logic                 dp_n_q;
    logic [DIGITS-1:0]    an_q;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        unique case (n)
            4'h0: f = 7'b0000001;
            4'h1: f = 7'b1001111;
            4'h2: f = 7'b0010010;
            4'h3: f = 7'b0000110;
            4'h4: f = 7'b1001100;
            4'h5: f = 7'b0100100;
            4'h6: f = 7'b0100000;
            4'h7: f = 7'b0001111;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0000100;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b1100000;
            4'hC: f = 7'b0110001;
            4'hD: f = 7'b1000010;
            4'hE: f = 7'b0110000;
            4'hF: f = 7'b0111000;
        endcase
        return f;
    endfunction

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            fcnt     <= '0;
            phase_on <= 1'b1;
            sh_value <= '0;
            sh_dp    <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (fcnt == FRM_MAX) begin
                    fcnt     <= '0;
                    phase_on <= ~phase_on;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            if (bus.load) begin
                sh_value <= bus.value;
                sh_dp    <= bus.dp;
            end
        end
    end

    // A digit is suppressible when it and every more significant
    // nibble are zero; digit 0 always stays visible.
    always_comb begin
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run  = zero_run & (sh_value[4*k +: 4] == 4'h0);
            lz_sup[k] = zero_run && (k != 0);
        end
    end

    always_comb begin
        an_lit      = '1;
        an_lit[idx] = 1'b0;
    end

    assign nib  = sh_value[{idx, 2'b00} +: 4];
    assign dark = (cnt == '0)
               || bus.blank_mask[idx]
               || (bus.blink_mask[idx] && !phase_on)
               || (bus.lz_en && lz_sup[idx]);

    always_ff @(posedge clk) begin
        if (rst || dark) begin
            seg_q  <= '1;
            an_q   <= '1;
            dp_n_q <= 1'b1;
        end else begin
            seg_q  <= font(nib);
            an_q   <= an_lit;
            dp_n_q <= ~sh_dp[idx];
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp_n = dp_n_q;
endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: spec-level reference model driven by
// scenario tasks with randomized data and masks.
module tb_seven_segment_scan;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam logic [11:0] DARK = {7'b1111111, 4'b1111, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    int          t;
    logic [15:0] sh;
    logic [3:0]  sdp;

    logic [6:0] font_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_segment_scan_if #(.DIGITS(D)) bus ();

    seven_segment_scan #(
        .DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Display as a function of time since reset, taken straight from
    // the slot/frame/blink-period arithmetic.
    function automatic logic [11:0] model_out(
        input int tt, input logic [15:0] s, input logic [3:0] d,
        input logic [3:0] bm, input logic [3:0] km, input logic lz
    );
        int c, i, f;
        logic on, dk;
        logic [3:0] a;
        logic [3:0] n;
        c  = tt % SD;
        i  = (tt / SD) % D;
        f  = tt / (SD * D);
        on = ((f / BF) % 2) == 0;
        dk = (c == 0) || bm[i] || (km[i] && !on)
          || (lz && i > 0 && ((s >> (4 * i)) == 16'h0));
        if (dk) return DARK;
        a    = 4'hF;
        a[i] = 1'b0;
        n    = s[4*i +: 4];
        return {font_tab[n], a, ~d[i]};
    endfunction

    task automatic step(output logic [11:0] e);
        if (rst) e = DARK;
        else e = model_out(t, sh, sdp, bus.blank_mask,
                           bus.blink_mask, bus.lz_en);
        @(posedge clk);
        if (rst) begin
            t = 0; sh = '0; sdp = '0;
        end else begin
            t++;
            if (bus.load) begin
                sh = bus.value; sdp = bus.dp;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        bus.load = 1'b1; bus.value = 16'hFFFF; bus.dp = 4'hF;
        bus.blank_mask = '0; bus.blink_mask = '0; bus.lz_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(e);
            vectors++;
            if ({bus.seg, bus.an, bus.dp_n} !== DARK) begin
                errors++;
                $display("FAIL reset_hold k=%0d got %b want %b",
                         k, {bus.seg, bus.an, bus.dp_n}, DARK);
            end
        end
        rst = 1'b0; bus.load = 1'b0;
        for (int k = 0; k < SD * D; k++) begin
            step(e);
            vectors++;
            if ({bus.seg, bus.an, bus.dp_n} !== e ||
                (e[4:1] != 4'hF && bus.seg !== 7'b0000001)) begin
                errors++;
                $display("FAIL reset_frame k=%0d got %b want %b",
                         k, {bus.seg, bus.an, bus.dp_n}, e);
            end
        end
    endtask

    task automatic test_scan_order();
        logic [11:0] e;
        logic [6:0]  w;
        logic        wd;
        bus.load = 1'b1; bus.value = 16'h1234; bus.dp = 4'b0100;
        step(e);
        bus.load = 1'b0;
        for (int k = 0; k < 2 * SD * D; k++) begin
            step(e);
            w  = 7'b1111111;
            wd = 1'b1;
            case (e[4:1])
                4'b1110: w = 7'b1001100;
                4'b1101: w = 7'b0000110;
                4'b1011: begin w = 7'b0010010; wd = 1'b0; end
                4'b0111: w = 7'b1001111;
                default: ;
            endcase
            vectors++;
            if ({bus.seg, bus.an, bus.dp_n} !== e ||
                bus.seg !== w || bus.dp_n !== wd) begin
                errors++;
                $display("FAIL scan_order k=%0d got %b want %b seg %b",
                         k, {bus.seg, bus.an, bus.dp_n}, e, w);
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [11:0] e;
        logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'hA000};
        int lit3;
        bus.lz_en = 1'b1;
        for (int v = 0; v < 3; v++) begin
            bus.load = 1'b1; bus.value = vals[v]; bus.dp = 4'($urandom);
            step(e);
            bus.load = 1'b0;
            lit3 = 0;
            for (int k = 0; k < SD * D + 4; k++) begin
                step(e);
                if (bus.an === 4'b0111) lit3++;
                vectors++;
                if ({bus.seg, bus.an, bus.dp_n} !== e ||
                    (bus.an === 4'b0111 && bus.seg !== 7'b0001000)) begin
                    errors++;
                    $display("FAIL lz v=%h k=%0d got %b want %b",
                             vals[v], k, {bus.seg, bus.an, bus.dp_n}, e);
                end
            end
            vectors++;
            if ((v == 2) != (lit3 > 0)) begin
                errors++;
                $display("FAIL lz_digit3 v=%h lit_cycles=%0d",
                         vals[v], lit3);
            end
        end
        bus.lz_en = 1'b0;
    endtask

    task automatic test_blink();
        logic [11:0] e;
        int tb0, lit [3];
        rst = 1'b1;
        step(e);
        rst = 1'b0;
        bus.blink_mask = 4'b0001;
        bus.load = 1'b1; bus.value = 16'($urandom); bus.dp = 4'($urandom);
        lit = '{0, 0, 0};
        for (int k = 0; k < 6 * SD * D; k++) begin
            tb0 = t;
            step(e);
            bus.load = 1'b0;
            if (bus.an === 4'b1110) lit[tb0 / (2 * SD * D)]++;
            vectors++;
            if ({bus.seg, bus.an, bus.dp_n} !== e) begin
                errors++;
                $display("FAIL blink k=%0d got %b want %b",
                         k, {bus.seg, bus.an, bus.dp_n}, e);
            end
        end
        vectors++;
        if (lit[0] != 2 * (SD - 1) || lit[1] != 0 ||
            lit[2] != 2 * (SD - 1)) begin
            errors++;
            $display("FAIL blink_phase lit=%0d/%0d/%0d want 6/0/6",
                     lit[0], lit[1], lit[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        logic [3:0]  wa;
        logic [6:0]  ws;
        bus.load = 1'b1; bus.value = 16'hBEEF; bus.dp = 4'hF;
        step(e);
        bus.load = 1'b0;
        for (int g = 0; g < SD * D && (t % (SD * D)) != 2 * SD + 2; g++)
            step(e);
        rst = 1'b1; bus.load = 1'b1; bus.value = 16'h5555;
        step(e);
        vectors++;
        if ({bus.seg, bus.an, bus.dp_n} !== DARK) begin
            errors++;
            $display("FAIL reset_mid got %b want %b",
                     {bus.seg, bus.an, bus.dp_n}, DARK);
        end
        rst = 1'b0; bus.load = 1'b0;
        for (int k = 0; k < SD * D; k++) begin
            step(e);
            wa = 4'hF;
            ws = 7'b1111111;
            if (k % SD != 0) begin
                wa[k / SD] = 1'b0;
                ws = 7'b0000001;
            end
            vectors++;
            if (bus.an !== wa || bus.seg !== ws || bus.dp_n !== 1'b1
                || {bus.seg, bus.an, bus.dp_n} !== e) begin
                errors++;
                $display("FAIL reset_restart k=%0d got %b want %b",
                         k, {bus.seg, bus.an, bus.dp_n}, {ws, wa, 1'b1});
            end
        end
        bus.blink_mask = '0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        logic [15:0] v;
        v = 16'($urandom);
        bus.load = 1'b1;
        for (int k = 0; k < 200; k++) begin
            bus.value = v;
            bus.dp    = 4'($urandom);
            bus.lz_en = 1'($urandom);
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            v = v + 16'h1;
            step(e);
            vectors++;
            if ({bus.seg, bus.an, bus.dp_n} !== e ||
                $countones(~bus.an) > 1) begin
                errors++;
                $display("FAIL back_to_back k=%0d got %b want %b",
                         k, {bus.seg, bus.an, bus.dp_n}, e);
            end
        end
        bus.load = 1'b0; bus.blank_mask = '0; bus.lz_en = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] e;
        for (int k = 0; k < 300; k++) begin
            rst            = ($urandom_range(0, 60) == 0);
            bus.load       = 1'($urandom);
            bus.value      = ($urandom_range(0, 1) == 0)
                           ? 16'($urandom_range(0, 255)) : 16'($urandom);
            bus.dp         = 4'($urandom);
            bus.blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus.blink_mask = 4'($urandom);
            bus.lz_en      = 1'($urandom);
            step(e);
            vectors++;
            if ({bus.seg, bus.an, bus.dp_n} !== e ||
                $countones(~bus.an) > 1) begin
                errors++;
                $display("FAIL random k=%0d got %b want %b",
                         k, {bus.seg, bus.an, bus.dp_n}, e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        t = 0; sh = '0; sdp = '0;
        test_reset();
        test_scan_order();
        test_leading_zeros();
        test_blink();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
